// File: rtl/w_sched_gen.sv
// w_sched_gen: SHA-256 message-schedule generator; loads W[0..15] into w_ram, expands W[16..63] in place.
// Ports: start/busy/done control; msg_valid/msg_ready/msg_data word stream (W[0] first);
// ram_we/ram_addr_W/ram_data_in drive the w_ram write port (combinational during writes);
// ram_addr_R1..R4 (registered) select W[t-2], W[t-7], W[t-15], W[t-16]; ram_data_out1..4 return them a cycle later.
// Define W_SCHED_PIPE_EN for one-word-per-cycle expansion; otherwise expansion alternates address/write phases.
module w_sched_gen #(
  parameter int BW = 31,
  parameter int wAddr_BW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                msg_valid,
  input  logic [BW:0]         msg_data,
  output logic                msg_ready,
  output logic                ram_we,
  output logic [wAddr_BW:0]   ram_addr_W,
  output logic [BW:0]         ram_data_in,
  output logic [wAddr_BW:0]   ram_addr_R1,
  output logic [wAddr_BW:0]   ram_addr_R2,
  output logic [wAddr_BW:0]   ram_addr_R3,
  output logic [wAddr_BW:0]   ram_addr_R4,
  input  logic [BW:0]         ram_data_out1,
  input  logic [BW:0]         ram_data_out2,
  input  logic [BW:0]         ram_data_out3,
  input  logic [BW:0]         ram_data_out4,
  output logic                busy,
  output logic                done
);
  localparam int AW = wAddr_BW + 1;
  localparam logic [wAddr_BW:0] C2 = 2, C7 = 7, C15 = 15, C16 = 16, C63 = 63;
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, FIN} state_t;
  state_t state;
  logic [wAddr_BW:0] t;
  logic [wAddr_BW:0] wr_idx;
  logic ph;
  logic load_wr;
  logic exp_wr;
  logic [BW:0] w_new;
  function automatic logic [BW:0] sig0(input logic [BW:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [BW:0] sig1(input logic [BW:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  function automatic logic [4*AW-1:0] raddr(input logic [wAddr_BW:0] x);
    return {x - C2, x - C7, x - C15, x - C16};
  endfunction
  assign w_new = sig1(ram_data_out1) + ram_data_out2 + sig0(ram_data_out3) + ram_data_out4;
  assign load_wr = (state == LOAD) && msg_valid;
  // ph marks the cycle whose read data is valid, i.e. the write cycle
  assign exp_wr = (state == EXPAND) && ph;
  assign ram_we = load_wr | exp_wr;
  assign ram_addr_W = (state == LOAD) ? t : exp_wr ? wr_idx : '0;
  assign ram_data_in = load_wr ? msg_data : exp_wr ? w_new : '0;
`ifndef W_SCHED_PIPE_EN
  assign wr_idx = t;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t <= '0;
      ph <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      msg_ready <= 1'b0;
      {ram_addr_R1, ram_addr_R2, ram_addr_R3, ram_addr_R4} <= '0;
`ifdef W_SCHED_PIPE_EN
      wr_idx <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          busy <= 1'b1;
          msg_ready <= 1'b1;
          t <= '0;
        end
        LOAD: if (msg_valid) begin
          if (t == C15) begin
            state <= EXPAND;
            msg_ready <= 1'b0;
            t <= C16;
            ph <= 1'b0;
            {ram_addr_R1, ram_addr_R2, ram_addr_R3, ram_addr_R4} <= raddr(C16);
          end else t <= t + 1'b1;
        end
`ifdef W_SCHED_PIPE_EN
        // t is the index whose addresses are on the bus; wr_idx trails it by one
        EXPAND: if (ph && wr_idx == C63) begin
          state <= FIN;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          ph <= 1'b1;
          wr_idx <= t;
          if (t != C63) begin
            t <= t + 1'b1;
            {ram_addr_R1, ram_addr_R2, ram_addr_R3, ram_addr_R4} <= raddr(t + 1'b1);
          end
        end
`else
        EXPAND: if (!ph) ph <= 1'b1;
        else if (t == C63) begin
          state <= FIN;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          ph <= 1'b0;
          t <= t + 1'b1;
          {ram_addr_R1, ram_addr_R2, ram_addr_R3, ram_addr_R4} <= raddr(t + 1'b1);
        end
`endif
        FIN: begin
          state <= IDLE;
          t <= '0;
          ph <= 1'b0;
          {ram_addr_R1, ram_addr_R2, ram_addr_R3, ram_addr_R4} <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_w_sched_gen.sv
// tb_w_sched_gen: directed bench for w_sched_gen with a behavioural w_ram
module tb_w_sched_gen;
  logic clk = 1'b0;
  logic rst, start, msg_valid;
  logic [31:0] msg_data;
  logic msg_ready, ram_we, busy, done;
  logic [5:0] ram_addr_W, ram_addr_R1, ram_addr_R2, ram_addr_R3, ram_addr_R4;
  logic [31:0] ram_data_in, ram_data_out1, ram_data_out2, ram_data_out3, ram_data_out4;
  logic clr = 1'b0;
  logic [31:0] mem [64];
  logic [5:0] a1, a2, a3, a4;
  logic [31:0] blk [16];
  logic [31:0] exp_w [64];
  int n_checks = 0;
  int n_fail = 0;
`ifdef W_SCHED_PIPE_EN
  localparam int LAT = 67;
`else
  localparam int LAT = 114;
`endif

  w_sched_gen dut (
    .clk(clk), .rst(rst), .start(start), .msg_valid(msg_valid), .msg_data(msg_data),
    .msg_ready(msg_ready), .ram_we(ram_we), .ram_addr_W(ram_addr_W), .ram_data_in(ram_data_in),
    .ram_addr_R1(ram_addr_R1), .ram_addr_R2(ram_addr_R2), .ram_addr_R3(ram_addr_R3), .ram_addr_R4(ram_addr_R4),
    .ram_data_out1(ram_data_out1), .ram_data_out2(ram_data_out2),
    .ram_data_out3(ram_data_out3), .ram_data_out4(ram_data_out4),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 64; i++) mem[i] <= 32'hDEADBEEF;
    else if (ram_we) mem[ram_addr_W] <= ram_data_in;
    a1 <= ram_addr_R1;
    a2 <= ram_addr_R2;
    a3 <= ram_addr_R3;
    a4 <= ram_addr_R4;
  end
  assign ram_data_out1 = mem[a1];
  assign ram_data_out2 = mem[a2];
  assign ram_data_out3 = mem[a3];
  assign ram_data_out4 = mem[a4];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model();
    for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
    for (int i = 16; i < 64; i++) exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7] + ssig0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic clear_mem();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic check_ram(input string name);
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (mem[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL %s ram[%0d]: got %08h expected %08h", name, i, mem[i], exp_w[i]);
      end
    end
  endtask

  // Runs one block; junk is driven on msg_valid/msg_data whenever no word is due
  task automatic run_block(input int gap_at, input int gap_len, input int restart_at,
                           output int lat, output int ndone);
    int idx, gapc;
    idx = 0; gapc = 0; lat = 0; ndone = 0;
    @(negedge clk);
    start = 1'b1;
    msg_valid = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      if (done) begin
        ndone++;
        if (lat == 0) lat = cyc + 1;
      end
      if (lat != 0 && cyc >= lat + 8) break;
      if (idx == gap_at && gapc < gap_len) begin
        msg_valid = 1'b0;
        msg_data = 32'hBAD0BAD0;
        gapc++;
        #1;
        n_checks++;
        if (ram_we !== 1'b0 || msg_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_gap: ram_we=%b msg_ready=%b expected 0 and 1", ram_we, msg_ready);
        end
      end else if (idx < 16 && msg_ready) begin
        msg_valid = 1'b1;
        msg_data = blk[idx];
        idx++;
      end else begin
        msg_valid = 1'b1;
        msg_data = 32'hFACEFEED;
      end
    end
    msg_valid = 1'b0;
    n_checks++;
    if (lat == 0) begin
      n_fail++;
      $display("FAIL done_timeout: no done within 400 cycles");
    end
  endtask

  task automatic check_run(input string name, input int lat, input int exp_lat, input int ndone);
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (ndone !== 1) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d expected 1", name, ndone);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; msg_valid = 1'b1; msg_data = 32'h12345678;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({msg_ready, ram_we, busy, done} !== 4'b0 || ram_addr_W !== 6'd0 || ram_data_in !== 32'd0 ||
        {ram_addr_R1, ram_addr_R2, ram_addr_R3, ram_addr_R4} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b we=%b busy=%b done=%b aW=%0d din=%08h R=%0d/%0d/%0d/%0d expected all 0",
               msg_ready, ram_we, busy, done, ram_addr_W, ram_data_in, ram_addr_R1, ram_addr_R2, ram_addr_R3, ram_addr_R4);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ram_we !== 1'b0 || busy !== 1'b0 || msg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_valid: we=%b busy=%b ready=%b expected 0/0/0", ram_we, busy, msg_ready);
    end
    msg_valid = 1'b0;
  endtask

  task automatic test_abc();
    int lat, nd;
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0] = 32'h61626380;
    blk[15] = 32'h00000018;
    build_model();
    clear_mem();
    run_block(-1, 0, 0, lat, nd);
    check_run("abc", lat, LAT, nd);
    n_checks++;
    if (mem[16] !== 32'h61626380) begin
      n_fail++;
      $display("FAIL abc_w16: got %08h expected 61626380", mem[16]);
    end
    n_checks++;
    if (mem[17] !== 32'h000F0000) begin
      n_fail++;
      $display("FAIL abc_w17: got %08h expected 000f0000", mem[17]);
    end
    check_ram("abc");
  endtask

  task automatic test_stall();
    int lat, nd;
    clear_mem();
    run_block(8, 5, 0, lat, nd);
    check_run("stall", lat, LAT + 5, nd);
    check_ram("stall");
  endtask

  task automatic test_restart_ignored();
    int lat, nd;
    for (int i = 0; i < 16; i++) blk[i] = (32'h01010101 * i) ^ 32'h5A5AC3C3;
    build_model();
    clear_mem();
    run_block(-1, 0, 40, lat, nd);
    check_run("restart", lat, LAT, nd);
    check_ram("restart");
  endtask

  task automatic test_rst_mid();
    int idx, bad, lat, nd;
    bit hit;
    idx = 0; bad = 0; hit = 1'b0;
    clear_mem();
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 300 && !hit; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (idx < 16 && msg_ready) begin
        msg_valid = 1'b1;
        msg_data = blk[idx];
        idx++;
      end else msg_valid = 1'b0;
      #1;
      hit = ram_we && ram_addr_W == 6'd30;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rst_mid_reach_t30: write of W[30] not seen");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || ram_we !== 1'b0 || msg_ready !== 1'b0 || ram_addr_W !== 6'd0 ||
        {ram_addr_R1, ram_addr_R2, ram_addr_R3, ram_addr_R4} !== 24'd0) begin
      n_fail++;
      $display("FAIL rst_mid_idle: busy=%b we=%b ready=%b aW=%0d expected 0/0/0/0 with R addrs 0",
               busy, ram_we, msg_ready, ram_addr_W);
    end
    msg_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    msg_valid = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: %0d active cycles after reset, expected 0", bad);
    end
    for (int i = 0; i < 16; i++) blk[i] = 32'h80000001 + (32'h11111111 * i);
    build_model();
    run_block(-1, 0, 0, lat, nd);
    check_run("after_rst", lat, LAT, nd);
    check_ram("after_rst");
  endtask

  task automatic test_all_ones();
    int lat, nd;
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
    build_model();
    clear_mem();
    run_block(-1, 0, 0, lat, nd);
    check_run("all_ones", lat, LAT, nd);
    check_ram("all_ones");
  endtask

  initial begin
    test_reset();
    test_abc();
    test_stall();
    test_restart_ignored();
    test_rst_mid();
    test_all_ones();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
